// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches 18-bit instruction words, presents decoded fields
// downstream and resolves jumps, branch-to-subroutine and return on the accept edge.
module pc_sequencer #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned STK_D = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [PC_W-1:0] pm_addr,
  output logic            pm_rd,
  input  logic [17:0]     pm_data,
  output logic [7:0]      OPCODE,
  output logic [4:0]      Ri,
  output logic [4:0]      Rj,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            w_zero,
  input  logic            w_msb,
  input  logic            cy,
  output logic [PC_W-1:0] pc,
  output logic            stk_err
);

  localparam int unsigned AW  = (STK_D > 1) ? $clog2(STK_D) : 1;
  localparam int unsigned SPW = $clog2(STK_D + 1);

  typedef enum logic [1:0] {StFetch, StLoad, StIssue} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pm_addr_q, pm_addr_d;
  logic            pm_rd_q, pm_rd_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [4:0]      ri_q, ri_d, rj_q, rj_d;
  logic            valid_q, valid_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic            err_q, err_d;
  logic            push;
  logic [PC_W-1:0] stk_q [STK_D];

  logic [PC_W-1:0] tgt, offs, pc_inc;
  logic [AW-1:0]   top_idx;

  assign tgt     = PC_W'({ri_q, rj_q});
  assign offs    = PC_W'($signed({ri_q, rj_q}));
  assign pc_inc  = pc_q + PC_W'(1);
  assign top_idx = AW'(sp_q - SPW'(1));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pm_addr_d = pm_addr_q;
    pm_rd_d   = 1'b0;
    opcode_d  = opcode_q;
    ri_d      = ri_q;
    rj_d      = rj_q;
    valid_d   = valid_q;
    sp_d      = sp_q;
    err_d     = err_q;
    push      = 1'b0;
    unique case (state_q)
      // The strobe is registered, so FETCH spends one cycle raising it and one with it visible
      // only when entered from reset; after an accept the strobe is raised on the accept edge.
      StFetch: begin
        if (pm_rd_q) begin
          state_d = StLoad;
        end else begin
          pm_rd_d   = 1'b1;
          pm_addr_d = pc_q;
        end
      end
      StLoad: begin
        opcode_d = pm_data[17:10];
        ri_d     = pm_data[9:5];
        rj_d     = pm_data[4:0];
        valid_d  = 1'b1;
        state_d  = StIssue;
      end
      StIssue: begin
        if (instr_ready) begin
          casez (opcode_q)
            8'b00100???: pc_d = tgt;
            8'b00101???: pc_d = w_zero ? tgt : pc_inc;
            8'b00110???: pc_d = !w_msb ? tgt : pc_inc;
            8'b00111???: pc_d = cy ? tgt : pc_inc;
            8'b000111??: begin
              pc_d = pc_q + offs;
              if (sp_q == SPW'(STK_D)) begin
                err_d = 1'b1;
              end else begin
                push = 1'b1;
                sp_d = sp_q + SPW'(1);
              end
            end
            8'b01000001: begin
              if (sp_q == '0) begin
                pc_d  = pc_inc;
                err_d = 1'b1;
              end else begin
                pc_d = stk_q[top_idx] + PC_W'(1);
                sp_d = sp_q - SPW'(1);
              end
            end
            default: pc_d = pc_inc;
          endcase
          valid_d   = 1'b0;
          pm_rd_d   = 1'b1;
          pm_addr_d = pc_d;
          state_d   = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      pc_q      <= '0;
      pm_addr_q <= '0;
      pm_rd_q   <= 1'b0;
      opcode_q  <= '0;
      ri_q      <= '0;
      rj_q      <= '0;
      valid_q   <= 1'b0;
      sp_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pm_addr_q <= pm_addr_d;
      pm_rd_q   <= pm_rd_d;
      opcode_q  <= opcode_d;
      ri_q      <= ri_d;
      rj_q      <= rj_d;
      valid_q   <= valid_d;
      sp_q      <= sp_d;
      err_q     <= err_d;
    end
  end

  // Stack storage needs no reset; the pointer alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      stk_q[sp_q[AW-1:0]] <= pc_q;
    end
  end

  assign pm_addr     = pm_addr_q;
  assign pm_rd       = pm_rd_q;
  assign OPCODE      = opcode_q;
  assign Ri          = ri_q;
  assign Rj          = rj_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign stk_err     = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random instructions, each checked
// against a queue-based reference model of the program counter and return stack.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  pm_addr;
  logic        pm_rd;
  logic [17:0] pm_data = '0;
  logic [7:0]  OPCODE;
  logic [4:0]  Ri, Rj;
  logic        instr_valid;
  logic        instr_ready;
  logic        w_zero, w_msb, cy;
  logic [9:0]  pc;
  logic        stk_err;

  pc_sequencer #(.PC_W(10), .STK_D(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pm_addr    (pm_addr),
    .pm_rd      (pm_rd),
    .pm_data    (pm_data),
    .OPCODE     (OPCODE),
    .Ri         (Ri),
    .Rj         (Rj),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .w_zero     (w_zero),
    .w_msb      (w_msb),
    .cy         (cy),
    .pc         (pc),
    .stk_err    (stk_err)
  );

  always #5 clk = ~clk;

  logic [17:0] mem [1024];
  always @(posedge clk) if (pm_rd) pm_data <= mem[pm_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int mpc      = 0;
  int stk[$];
  bit merr     = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  // Reference model of one retired instruction.
  task automatic model_step(input logic [17:0] w, input bit z, input bit m, input bit c);
    int op, x, s;
    op = int'(w[17:10]);
    x  = int'(w[9:0]);
    s  = (x >= 512) ? x - 1024 : x;
    if ((op >> 3) == 4)      mpc = x;
    else if ((op >> 3) == 5) mpc = z  ? x : (mpc + 1) % 1024;
    else if ((op >> 3) == 6) mpc = !m ? x : (mpc + 1) % 1024;
    else if ((op >> 3) == 7) mpc = c  ? x : (mpc + 1) % 1024;
    else if ((op >> 2) == 7) begin
      if (stk.size() < 4) stk.push_back(mpc);
      else merr = 1'b1;
      mpc = (mpc + s + 1024) % 1024;
    end else if (op == 'h41) begin
      if (stk.size() == 0) begin
        merr = 1'b1;
        mpc  = (mpc + 1) % 1024;
      end else begin
        mpc = (stk.pop_back() + 1) % 1024;
      end
    end else begin
      mpc = (mpc + 1) % 1024;
    end
  endtask

  // Starts on a falling edge with the DUT fetching from mpc; ends on the falling edge after accept.
  task automatic run_instr(input logic [17:0] w, input int exp_lat, input int stall,
                           input bit z, input bit m, input bit c);
    int lat = 0;
    mem[mpc] = w;
    while (!instr_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("instr_valid_seen", 32'(instr_valid), 32'd1);
    if (!instr_valid) begin
      summary();
      $finish;
    end
    check("issue_latency", 32'(lat), 32'(exp_lat));
    check("fields", {14'd0, OPCODE, Ri, Rj}, {14'd0, w});
    check("pc_at_issue", 32'(pc), 32'(mpc));
    for (int k = 0; k < stall; k++) begin
      instr_ready = 1'b0;
      cy     = ~cy;
      w_zero = 1'($urandom);
      w_msb  = 1'($urandom);
      @(negedge clk);
      check("stall_fields", {14'd0, OPCODE, Ri, Rj}, {14'd0, w});
      check("stall_pc_rd_valid", {20'd0, pc, pm_rd, instr_valid}, {20'd0, 10'(mpc), 1'b0, 1'b1});
    end
    w_zero = z;
    w_msb  = m;
    cy     = c;
    instr_ready = 1'b1;
    @(posedge clk);
    model_step(w, z, m, c);
    @(negedge clk);
    instr_ready = 1'b0;
    w_zero = 1'($urandom);
    w_msb  = 1'($urandom);
    cy     = 1'($urandom);
    check("next_pc", 32'(pc), 32'(mpc));
    check("fetch_rd_addr_valid", {20'd0, pm_rd, pm_addr, instr_valid},
          {20'd0, 1'b1, 10'(mpc), 1'b0});
    check("stk_err", 32'(stk_err), 32'(merr));
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("first_fetch", {21'd0, pm_rd, pm_addr}, {21'd0, 1'b1, 10'd0});
  endtask

  function automatic logic [17:0] mk(input logic [7:0] op, input int x);
    mk = {op, 10'(x)};
  endfunction

  initial begin
    int cls;
    logic [7:0] op;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    reset_n = 1'b0;
    instr_ready = 1'b0;
    w_zero = 1'b0;
    w_msb  = 1'b0;
    cy     = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {8'd0, pc, pm_addr, pm_rd, instr_valid, stk_err, 1'b0},
          32'd0);
    check("reset_fields", {14'd0, OPCODE, Ri, Rj}, 32'd0);
    release_reset();

    // First word after reset; one negedge already consumed by release_reset.
    run_instr(18'h000FF, 2, 0, 0, 0, 0);
    run_instr(mk(8'h20, 4), 2, 0, 0, 0, 0);         // JMP 4
    run_instr(mk(8'h28, 'h155), 2, 0, 1, 0, 0);     // JZE taken
    run_instr(mk(8'h20, 4), 2, 0, 0, 0, 0);
    run_instr(mk(8'h28, 'h155), 2, 0, 0, 0, 0);     // JZE not taken -> 5
    run_instr(mk(8'h38, 'h200), 2, 5, 0, 0, 0);     // JCY with stall, cy=0 at accept
    run_instr(mk(8'h3B, 'h030), 2, 5, 0, 0, 1);     // JCY with stall, cy=1 at accept
    run_instr(mk(8'h30, 'h040), 2, 0, 0, 1, 0);     // JNE not taken
    run_instr(mk(8'h31, 'h00A), 2, 0, 0, 0, 0);     // JNE taken -> 10
    run_instr(mk(8'h1C, 'h3FD), 2, 0, 0, 0, 0);     // BSR -3 -> 7
    run_instr(mk(8'h41, 0), 2, 0, 0, 0, 0);         // RET -> 11
    for (int i = 0; i < 5; i++) run_instr(mk(8'h1D, 2), 2, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) run_instr(mk(8'h41, 0), 2, 0, 0, 0, 0);
    run_instr(mk(8'h27, 'h3FF), 2, 0, 0, 0, 0);     // JMP 0x3FF
    run_instr(mk(8'h00, 0), 2, 0, 0, 0, 0);         // NOP wraps to 0
    run_instr(mk(8'h20, 5), 2, 0, 0, 0, 0);
    run_instr(mk(8'h1F, 'h3FA), 2, 0, 0, 0, 0);     // BSR -6 from 5 -> 1023
    run_instr(mk(8'h41, 0), 2, 0, 0, 0, 0);         // RET -> 6

    // Reset pulsed during LOAD abandons the instruction.
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_pc_valid_err", {20'd0, pc, instr_valid, stk_err}, 32'd0);
    check("midreset_rd_addr", {21'd0, pm_rd, pm_addr}, 32'd0);
    mpc = 0;
    stk.delete();
    merr = 1'b0;
    release_reset();
    run_instr(mk(8'h41, 0), 2, 0, 0, 0, 0);         // RET on empty stack after reset

    for (int i = 0; i < 60; i++) begin
      cls = int'($urandom_range(0, 7));
      case (cls)
        0: op = 8'h20 | 8'($urandom_range(0, 7));
        1: op = 8'h28 | 8'($urandom_range(0, 7));
        2: op = 8'h30 | 8'($urandom_range(0, 7));
        3: op = 8'h38 | 8'($urandom_range(0, 7));
        4: op = 8'h1C | 8'($urandom_range(0, 3));
        5: op = 8'h41;
        6: op = 8'($urandom);
        default: op = 8'h00;
      endcase
      run_instr(mk(op, int'($urandom_range(0, 1023))), 2, int'($urandom_range(0, 2)),
                1'($urandom), 1'($urandom), 1'($urandom));
    end

    summary();
    $finish;
  end

endmodule
